// File: rtl/decode_pkg.sv
// Shared constants for the instruction-decode stage: default geometry,
// field-position helpers and the skid-buffer occupancy encoding.
package decode_pkg;

    localparam int DEF_INST_W = 32;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_IMM_W  = 32;
    localparam int DEF_CNT_W  = 16;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Address field is whatever remains below the opcode and three register fields.
    function automatic int addr_width(input int inst_w, input int op_w, input int reg_w);
        return inst_w - op_w - 3 * reg_w;
    endfunction

    function automatic int reg_msb(input int inst_w, input int op_w, input int reg_w, input int k);
        return inst_w - op_w - 1 - k * reg_w;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_if
    import decode_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int ADDR_W = addr_width(INST_W, OP_W, REG_W);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] inst;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  reg_addr_0;
    logic [REG_W-1:0]  reg_addr_1;
    logic [REG_W-1:0]  reg_addr_2;
    logic [ADDR_W-1:0] addr;
    logic [IMM_W-1:0]  imm;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    modport slave (
        input  flush, in_valid, inst, out_ready,
        output in_ready, out_valid, opcode, reg_addr_0, reg_addr_1, reg_addr_2,
               addr, imm, illegal, illegal_cnt
    );

    modport master (
        output flush, in_valid, inst, out_ready,
        input  in_ready, out_valid, opcode, reg_addr_0, reg_addr_1, reg_addr_2,
               addr, imm, illegal, illegal_cnt
    );

endinterface

// File: rtl/decode_fields.sv
// Combinational split of one instruction word into opcode, register
// addresses and extended immediate, plus the opcode legality check.
module decode_fields
    import decode_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter logic [2**OP_W-1:0] OP_LEGAL = {(2**OP_W){1'b1}},
    parameter logic [2**OP_W-1:0] OP_SEXT  = {(2**OP_W){1'b0}},
    localparam int ADDR_W = addr_width(INST_W, OP_W, REG_W)
) (
    input  logic [INST_W-1:0] inst_i,
    output logic [OP_W-1:0]   opcode_o,
    output logic [REG_W-1:0]  ra0_o,
    output logic [REG_W-1:0]  ra1_o,
    output logic [REG_W-1:0]  ra2_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [IMM_W-1:0]  imm_o,
    output logic              illegal_o
);
    localparam int RA0_MSB = reg_msb(INST_W, OP_W, REG_W, 0);
    localparam int RA1_MSB = reg_msb(INST_W, OP_W, REG_W, 1);
    localparam int RA2_MSB = reg_msb(INST_W, OP_W, REG_W, 2);

    // Bitwise build also covers IMM_W == ADDR_W, where no extension bits exist.
    function automatic logic [IMM_W-1:0] extend(input logic [ADDR_W-1:0] a, input logic sext);
        logic [IMM_W-1:0] r;
        for (int i = 0; i < IMM_W; i++) begin
            r[i] = (i < ADDR_W) ? a[i] : (sext & a[ADDR_W-1]);
        end
        return r;
    endfunction

    assign opcode_o  = inst_i[INST_W-1 -: OP_W];
    assign ra0_o     = inst_i[RA0_MSB -: REG_W];
    assign ra1_o     = inst_i[RA1_MSB -: REG_W];
    assign ra2_o     = inst_i[RA2_MSB -: REG_W];
    assign addr_o    = inst_i[ADDR_W-1:0];
    assign imm_o     = extend(addr_o, OP_SEXT[opcode_o]);
    assign illegal_o = ~OP_LEGAL[opcode_o];

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input side, holds up to two
// decoded entries (output register + skid) and counts illegal opcodes.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter logic [2**OP_W-1:0] OP_LEGAL = {(2**OP_W){1'b1}},
    parameter logic [2**OP_W-1:0] OP_SEXT  = {(2**OP_W){1'b0}},
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic     clk,
    input logic     rst,
    decode_if.slave dec_if
);
    localparam int ADDR_W = addr_width(INST_W, OP_W, REG_W);

    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("decode_stage: INST_W leaves no room for the address field");
    end
    if (IMM_W < ADDR_W) begin : g_bad_imm_w
        $error("decode_stage: IMM_W must be at least ADDR_W");
    end

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [REG_W-1:0]  ra0;
        logic [REG_W-1:0]  ra1;
        logic [REG_W-1:0]  ra2;
        logic [ADDR_W-1:0] addr;
        logic [IMM_W-1:0]  imm;
        logic              illegal;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic [OP_W-1:0]   f_op;
    logic [REG_W-1:0]  f_ra0, f_ra1, f_ra2;
    logic [ADDR_W-1:0] f_addr;
    logic [IMM_W-1:0]  f_imm;
    logic              f_ill;
    entry_t            dec_in;

    decode_fields #(
        .INST_W  (INST_W),
        .OP_W    (OP_W),
        .REG_W   (REG_W),
        .IMM_W   (IMM_W),
        .OP_LEGAL(OP_LEGAL),
        .OP_SEXT (OP_SEXT)
    ) u_fields (
        .inst_i   (dec_if.inst),
        .opcode_o (f_op),
        .ra0_o    (f_ra0),
        .ra1_o    (f_ra1),
        .ra2_o    (f_ra2),
        .addr_o   (f_addr),
        .imm_o    (f_imm),
        .illegal_o(f_ill)
    );

    assign dec_in = {f_op, f_ra0, f_ra1, f_ra2, f_addr, f_imm, f_ill};

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, out_valid_q;
    entry_t           out_q, out_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer, out_xfer;

    assign in_xfer  = dec_if.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & dec_if.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    out_d   = dec_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = dec_in;
                end else if (in_xfer) begin
                    skid_d  = dec_in;
                    state_d = ST_TWO;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (dec_if.flush) begin
            state_d = ST_EMPTY;
        end
        cnt_d = (out_xfer && out_q.illegal) ? sat_inc(cnt_q) : cnt_q;
    end

    // ---- output register / control stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
            cnt_q       <= cnt_d;
            out_q       <= out_d;
        end
    end

    // ---- skid entry ----
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign dec_if.in_ready    = in_ready_q;
    assign dec_if.out_valid   = out_valid_q;
    assign dec_if.opcode      = out_q.opcode;
    assign dec_if.reg_addr_0  = out_q.ra0;
    assign dec_if.reg_addr_1  = out_q.ra1;
    assign dec_if.reg_addr_2  = out_q.ra2;
    assign dec_if.addr        = out_q.addr;
    assign dec_if.imm         = out_q.imm;
    assign dec_if.illegal     = out_q.illegal;
    assign dec_if.illegal_cnt = cnt_q;

endmodule
